equal_array_seq: RTL and testbench
==================================

# equal_array_seq

Sequential, parametrised array-equality checker. It compares two arrays of DEPTH words of WIDTH bits, streamed one word pair per accepted beat. It reports whole-array equality, the index of the first mismatching word, and the mismatch count. It is the multi-word, masked, handshaked successor to the single-word combinational equality comparator, and it sits between a memory or register-file reader and the control logic that needs a pass/fail verdict.

## Interface
Parameters:
- WIDTH, 6, bits per word.
- DEPTH, 8, words per array; legal range 2 and up.
- EARLY_EXIT, 0, mode select:
  - 0: scan all DEPTH words.
  - 1: finish on the first mismatch.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begins a comparison; honoured only in IDLE.
- mask, input, WIDTH, bit-compare enable; sampled on accepted start; a 0 bit excludes that bit from comparison.
- a, input, WIDTH, word of array A.
- b, input, WIDTH, word of array B.
- in_valid, input, 1, a/b hold a valid word pair.
- in_ready, output, 1, block accepts a word pair this cycle.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle result strobe.
- equ, output, 1, 1 when all compared words are equal under the mask.
- mismatch_idx, output, max(1,clog2(DEPTH)), index of the first mismatching word.
- mismatch_cnt, output, clog2(DEPTH+1), number of mismatching words seen.

## Operation
- Beat accepted when in_valid && in_ready. Word mismatch = |((a ^ b) & mask_q).
- Word index counter `widx` starts at 0 and increments on each accepted beat. There is no wrap: the last index is DEPTH-1.
- FSM states and transitions:
  - IDLE: in_ready=0, busy=0. On start, go to RUN and in the same edge:
    - latch mask into mask_q;
    - clear widx, mismatch_cnt and mismatch_idx;
    - set equ to 1, the provisional value.
  - RUN: in_ready=1, busy=1. On each accepted beat:
    - if the word mismatches: clear equ, increment mismatch_cnt, and load mismatch_idx with widx only if this is the first mismatch (mismatch_cnt was 0).
    - If widx==DEPTH-1, go to DONE.
    - If EARLY_EXIT=1 and the word mismatches, go to DONE immediately.
  - DONE: in_ready=0, busy=1, done=1 for exactly this cycle, then return to IDLE unconditionally.
- start in RUN or DONE is ignored. start in IDLE is accepted even if in_valid is high; no beat is accepted in that cycle.
- equ, mismatch_idx and mismatch_cnt hold their values after done until the next accepted start.
- When equ=1, mismatch_idx=0 and mismatch_cnt=0.
- mismatch_cnt saturates naturally at DEPTH, which is its maximum.
- a, b and in_valid are ignored outside RUN.

## Timing
- Reset values (asynchronous, effective immediately while rst=1):
  - state IDLE;
  - in_ready, busy, done, equ all 0;
  - mismatch_idx, mismatch_cnt, widx, mask_q all 0.
- Entry to RUN: start is sampled at edge T, and in_ready is high from T onward, so the first beat can be accepted at edge T+1.
- Latency:
  - done is high the cycle after the final accepted beat.
  - With continuous in_valid: done is high DEPTH+1 cycles after the start edge; the minimum start-to-start period is DEPTH+2 cycles.
- Results are valid in the done cycle. Outputs update on the same edge as the beat that produces them, so equ may fall mid-RUN. Consumers should qualify with done.
- Bubbles (in_valid low during RUN) stall the block with no state change. There is no timeout.
- Reset mid-RUN aborts the comparison. No done is produced and outputs return to their reset values; the next comparison requires a new start.

## Test plan
- Equal arrays, DEPTH=8, WIDTH=6, mask=6'h3F, in_valid held high, A=B={0..7} → done exactly 9 cycles after start edge; equ=1, mismatch_cnt=0, mismatch_idx=0.
- Mismatches at words 2 and 5 (b[2]=a[2]^6'h01, b[5]=a[5]^6'h20), mask=6'h3F → equ=0, mismatch_idx=2, mismatch_cnt=2.
- Same stimulus with mask=6'h1E → both differences masked off: equ=1, mismatch_cnt=0.
- in_valid toggled 1,0,0,1,… with 3 idle cycles inserted between beats 3 and 4 → identical result to the unstalled run; in_ready stays high throughout RUN; done appears one cycle after the 8th accepted beat. start pulsed mid-run has no effect.
- EARLY_EXIT=1, first mismatch at word 3 → done the cycle after beat 3; equ=0, mismatch_idx=3, mismatch_cnt=1; in_ready=0 from the DONE cycle on.
- rst asserted after 4 accepted beats → all outputs 0 immediately and no done pulse. A new start followed by an all-equal run then yields equ=1 with normal latency.

Source files
------------

// File: rtl/equal_array_seq.sv
// Streams two DEPTH-word arrays one word pair per beat and compares them under a bit mask.
// Reports whole-array equality, the first mismatching index and the mismatch count.
module equal_array_seq #(
    parameter  int WIDTH      = 6,
    parameter  int DEPTH      = 8,
    parameter  int EARLY_EXIT = 0,
    localparam int IW         = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             equ,
    output logic [IW-1:0]    mismatch_idx,
    output logic [CW-1:0]    mismatch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [IW-1:0]    widx_q, widx_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             equ_q, equ_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             word_mis;
    logic             last_word;
    logic             beat;

    assign word_mis  = |((a ^ b) & mask_q);
    assign last_word = (widx_q == IW'(DEPTH - 1));
    assign beat      = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        widx_d  = widx_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        equ_d   = equ_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mask_d  = mask;
                    widx_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    equ_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (beat) begin
                    if (word_mis) begin
                        equ_d = 1'b0;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == '0) begin
                            idx_d = widx_q;
                        end
                    end
                    // Hold widx at DEPTH-1 so a power-of-two DEPTH never wraps.
                    if (!last_word) begin
                        widx_d = widx_q + IW'(1);
                    end
                    if (last_word || (EARLY_EXIT != 0 && word_mis)) begin
                        state_d = S_DONE;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            widx_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            equ_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            widx_q  <= widx_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            equ_q   <= equ_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready     = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign equ          = equ_q;
    assign mismatch_idx = idx_q;
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_equal_array_seq.sv
// Scoreboard bench for equal_array_seq: a full-scan and an early-exit instance share stimulus.
// Expected results come from an array-level model; monitors pop and compare on done.
module tb_equal_array_seq;

    localparam int W = 6;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] mask = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         r0, bz0, dn0, eq0;
    logic [2:0]   ix0;
    logic [3:0]   ct0;
    logic         r1, bz1, dn1, eq1;
    logic [2:0]   ix1;
    logic [3:0]   ct1;

    equal_array_seq #(.WIDTH(W), .DEPTH(D), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(r0), .busy(bz0), .done(dn0),
        .equ(eq0), .mismatch_idx(ix0), .mismatch_cnt(ct0)
    );

    equal_array_seq #(.WIDTH(W), .DEPTH(D), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(r1), .busy(bz1), .done(dn1),
        .equ(eq1), .mismatch_idx(ix1), .mismatch_cnt(ct1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int equ;
        int idx;
        int cnt;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [W-1:0] ta[D];
    logic [W-1:0] tb_[D];
    int           bub[D];
    exp_t         last0;

    // Array-level reference: scan words, stop at first mismatch in early-exit mode.
    // cyc is the posedge count at which done becomes visible (last beat edge).
    function automatic exp_t model(input bit ee, input logic [W-1:0] m, input int sc);
        exp_t e;
        int   last;
        e.cnt = 0;
        e.idx = 0;
        last  = D - 1;
        for (int i = 0; i < D; i++) begin
            if (((ta[i] ^ tb_[i]) & m) != 0) begin
                if (e.cnt == 0) e.idx = i;
                e.cnt++;
                if (ee) begin
                    last = i;
                    break;
                end
            end
        end
        e.equ = (e.cnt == 0) ? 1 : 0;
        e.cyc = sc + last + 1;
        for (int i = 0; i <= last; i++) e.cyc += bub[i];
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && dn0) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done0_unexpected actual=1 expected=0");
            end else begin
                e = q0.pop_front();
                chk("full_equ", eq0, e.equ);
                chk("full_idx", ix0, e.idx);
                chk("full_cnt", ct0, e.cnt);
                chk("full_done_cycle", cyc, e.cyc);
                chk("full_ready_in_done", r0, 0);
                chk("full_busy_in_done", bz0, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && dn1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done1_unexpected actual=1 expected=0");
            end else begin
                e = q1.pop_front();
                chk("ee_equ", eq1, e.equ);
                chk("ee_idx", ix1, e.idx);
                chk("ee_cnt", ct1, e.cnt);
                chk("ee_done_cycle", cyc, e.cyc);
                chk("ee_ready_in_done", r1, 0);
                chk("ee_busy_in_done", bz1, 1);
            end
        end
    end

    task automatic run_txn(input logic [W-1:0] m, input bit pulse);
        exp_t e1;
        int   sc;
        @(negedge clk);
        start = 1'b1;
        mask  = m;
        @(posedge clk);
        #1;
        sc    = cyc;
        start = 1'b0;
        mask  = W'($urandom);
        last0 = model(1'b0, m, sc);
        e1    = model(1'b1, m, sc);
        q0.push_back(last0);
        q1.push_back(e1);
        chk("ready_after_start", r0, 1);
        for (int i = 0; i < D; i++) begin
            repeat (bub[i]) begin
                in_valid = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
                start = pulse;
                chk("ready_in_bubble", r0, 1);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            a = ta[i];
            b = tb_[i];
            chk("ready_at_beat", r0, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("hold_equ", eq0, last0.equ);
        chk("hold_cnt", ct0, last0.cnt);
        chk("idle_busy", bz0, 0);
    endtask

    task automatic set_equal();
        for (int i = 0; i < D; i++) begin
            ta[i]  = W'(i);
            tb_[i] = W'(i);
            bub[i] = 0;
        end
    endtask

    initial begin
        #1;
        chk("rst_ready", r0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_equ", eq0, 0);
        chk("rst_idx", ix0, 0);
        chk("rst_cnt", ct0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        set_equal();
        run_txn(6'h3F, 1'b0);

        tb_[2] = ta[2] ^ 6'h01;
        tb_[5] = ta[5] ^ 6'h20;
        run_txn(6'h3F, 1'b0);
        run_txn(6'h1E, 1'b0);

        set_equal();
        bub[1] = 2;
        bub[3] = 3;
        bub[5] = 2;
        run_txn(6'h3F, 1'b1);

        set_equal();
        tb_[3] = ta[3] ^ 6'h04;
        tb_[6] = ta[6] ^ 6'h10;
        run_txn(6'h3F, 1'b0);

        // Abort mid-run: four beats, then asynchronous reset.
        set_equal();
        @(negedge clk);
        start = 1'b1;
        mask  = 6'h3F;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = ta[i];
            b = tb_[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_ready", r0, 0);
        chk("abort_busy", bz0, 0);
        chk("abort_equ", eq0, 0);
        chk("abort_busy_ee", bz1, 0);
        chk("abort_ready_ee", r1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_busy", bz0, 0);
        run_txn(6'h3F, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < D; i++) begin
                ta[i]  = W'($urandom);
                tb_[i] = ($urandom_range(0, 1) == 0) ? ta[i] : W'($urandom);
                bub[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_txn(($urandom_range(0, 2) == 0) ? 6'h3F : W'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
